// File: rtl/weight_buffer.sv
// weight_buffer
//   Register-backed store of LAYER_NUM weight matrices, each
//   NEURON_NUM*NEURON_NUM signed cells of WEIGHT_CELL_WIDTH bits.
//
//   A transaction runs as follows:
//     1. A layer request is accepted in IDLE.
//     2. The selected matrix is presented on w (READ) until it is taken.
//     3. The block waits for the updated matrix on result (WAIT_WB).
//     4. That matrix is written back, done pulses, and the FSM returns to IDLE.
//   An out-of-range layer request is accepted and dropped, and layer_error
//   pulses.
//
//   Optional feature: define WEIGHT_BUFFER_ERR_DROP_EN to discard writebacks
//   flagged by result_error. The handshake still completes and done still
//   pulses. A saturating drop_count output counts the discarded writebacks.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   layer/layer_valid/ready     layer request handshake
//   w/w_valid/w_ready           current weights of the latched layer
//   result/result_valid/ready   updated weights to write back
//   result_error                overflow flag qualified by result_valid
//   done                        1-cycle pulse after a writeback handshake
//   layer_error                 1-cycle pulse after an out-of-range request
//   drop_count                  (WEIGHT_BUFFER_ERR_DROP_EN only) dropped writebacks

// One stored layer matrix; reset clears it, we loads it whole.
module weight_layer_reg #(
    parameter int WIDTH = 400
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (we) q <= d;
    end
endmodule

module weight_buffer #(
    parameter int NEURON_NUM        = 5,
    parameter int WEIGHT_CELL_WIDTH = 16,
    parameter int LAYER_NUM         = 2,
    parameter int LAYER_ADDR_WIDTH  = 2
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [LAYER_ADDR_WIDTH-1:0]                       layer,
    input  logic                                              layer_valid,
    output logic                                              layer_ready,
    output logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0] w,
    output logic                                              w_valid,
    input  logic                                              w_ready,
    input  logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0] result,
    input  logic                                              result_valid,
    output logic                                              result_ready,
    input  logic                                              result_error,
`ifdef WEIGHT_BUFFER_ERR_DROP_EN
    output logic [7:0]                                        drop_count,
`endif
    output logic                                              done,
    output logic                                              layer_error
);
    localparam int MAT_W = NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH;

    typedef enum logic [1:0] {IDLE, READ, WAIT_WB} state_t;

    state_t                      state, state_nxt;
    logic [LAYER_ADDR_WIDTH-1:0] lat;
    logic [LAYER_NUM-1:0][MAT_W-1:0] layer_q;
    logic [LAYER_NUM-1:0]        wr_en;

    logic layer_fire, layer_ok, wb_fire, wb_commit;

    assign layer_fire = layer_valid && layer_ready;
    assign layer_ok   = 32'(layer) < LAYER_NUM;
    assign wb_fire    = result_valid && result_ready;

`ifdef WEIGHT_BUFFER_ERR_DROP_EN
    assign wb_commit = wb_fire && !result_error;
`else
    assign wb_commit = wb_fire;
    // result_error has no function in this build.
    logic unused_result_error;
    assign unused_result_error = result_error;
`endif

    // Per-layer storage; only the latched layer can be written.
    for (genvar i = 0; i < LAYER_NUM; i++) begin : g_layer
        assign wr_en[i] = wb_commit && (lat == LAYER_ADDR_WIDTH'(i));
        weight_layer_reg #(.WIDTH(MAT_W)) u_reg (
            .clk (clk),
            .rst (rst),
            .we  (wr_en[i]),
            .d   (result),
            .q   (layer_q[i])
        );
    end

    // lat only ever holds an in-range index, and the selected matrix cannot
    // change while READ is active, so w is stable for the whole READ phase.
    always_comb begin
        w = '0;
        for (int i = 0; i < LAYER_NUM; i++)
            if (lat == LAYER_ADDR_WIDTH'(i)) w = layer_q[i];
    end

    always_comb begin
        state_nxt    = state;
        layer_ready  = 1'b0;
        w_valid      = 1'b0;
        result_ready = 1'b0;
        case (state)
            IDLE: begin
                layer_ready = 1'b1;
                if (layer_valid && layer_ok) state_nxt = READ;
            end
            READ: begin
                w_valid = 1'b1;
                if (w_ready) state_nxt = WAIT_WB;
            end
            WAIT_WB: begin
                result_ready = 1'b1;
                if (result_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lat         <= '0;
            done        <= 1'b0;
            layer_error <= 1'b0;
        end else begin
            state       <= state_nxt;
            done        <= wb_fire;
            layer_error <= layer_fire && !layer_ok;
            if (layer_fire && layer_ok) lat <= layer;
        end
    end

`ifdef WEIGHT_BUFFER_ERR_DROP_EN
    always_ff @(posedge clk) begin
        if (rst)
            drop_count <= 8'd0;
        else if (wb_fire && result_error && drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;
    end
`endif

endmodule
